// File: rtl/conv_mem_pkg.sv
// Shared types and helpers for the conv2d tensor memory responder.
// Contents:
//   conv_state_e - controller states, exported on the top-level debug port
//   ptr_width()  - pointer width for a memory of a given depth (minimum 1 bit)
package conv_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } conv_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_tensor_drain.sv
// Result-stream sequencer: walks the output tensor from address 0 to DEPTH-1
// over a valid/ready stream once started.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   drain_go_i        - one-cycle pulse that starts a drain (ignored while active)
//   rd_ready_i        - host accepts the current beat
//   rptr_o            - address of the beat currently presented
//   rd_valid_o        - beat valid
//   rd_last_o         - current beat is the final one
//   drain_done_o      - final beat handshakes this cycle
// Stream rule: a beat transfers on a rising edge where rd_valid_o and
// rd_ready_i are both high; while rd_ready_i is low the pointer (and thus the
// presented data and last flag) holds.
module conv_tensor_drain
  import conv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          drain_go_i,
  input  logic          rd_ready_i,
  output logic [PW-1:0] rptr_o,
  output logic          rd_valid_o,
  output logic          rd_last_o,
  output logic          drain_done_o
);

  localparam logic [PW-1:0] RPTR_LAST = PW'(DEPTH - 1);

  logic          active_q, active_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          is_last;
  logic          fire;

  assign is_last = (rptr_q == RPTR_LAST);
  assign fire    = active_q && rd_ready_i;

  always_comb begin
    active_d = active_q;
    rptr_d   = rptr_q;
    if (!active_q) begin
      if (drain_go_i) begin
        active_d = 1'b1;
        rptr_d   = '0;
      end
    end else if (fire) begin
      // Pointer parks at 0 after the last beat, so it never wraps.
      if (is_last) begin
        active_d = 1'b0;
        rptr_d   = '0;
      end else begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      rptr_q   <= '0;
    end else begin
      active_q <= active_d;
      rptr_q   <= rptr_d;
    end
  end

  assign rptr_o       = rptr_q;
  assign rd_valid_o   = active_q;
  assign rd_last_o    = active_q && is_last;
  assign drain_done_o = fire && is_last;

endmodule

// File: rtl/conv_tensor_mem.sv
// Synthesizable memory responder for one conv2d instance. Loads the input
// tensor from a host stream, pulses conv_start, serves conv2d reads, captures
// conv2d writes, and after conv_done streams the output tensor to the host.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   ld_valid/ld_ready/ld_data/ld_last - input tensor load stream (address order)
//   conv_start, conv_done            - conv2d start pulse / done input
//   input_addr/input_en/input_data   - conv2d combinational read port
//   output_addr/output_data/output_we/output_en - conv2d write port
//   rd_valid/rd_ready/rd_data/rd_last - output tensor result stream
//   busy                             - controller not idle
//   error                            - sticky load-length / address-range error
//   dbg_state                        - current controller state
// Stream rule (both streams): a beat transfers on a rising edge where valid
// and ready are both high; the source holds data/last stable until then.
module conv_tensor_mem
  import conv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IN_DEPTH   = 32,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  conv_start,
  input  logic                  conv_done,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  input  logic                  input_en,
  output logic [DATA_WIDTH-1:0] input_data,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  input  logic [DATA_WIDTH-1:0] output_data,
  input  logic                  output_we,
  input  logic                  output_en,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  error,
  output conv_state_e           dbg_state
);

  localparam int IN_PW  = ptr_width(IN_DEPTH);
  localparam int OUT_PW = ptr_width(OUT_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] IN_LIMIT  = ADDR_WIDTH'(IN_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OUT_LIMIT = ADDR_WIDTH'(OUT_DEPTH);
  localparam logic [IN_PW-1:0]      WPTR_LAST = IN_PW'(IN_DEPTH - 1);

  conv_state_e           state_q, state_d;
  logic [IN_PW-1:0]      wptr_q, wptr_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] in_mem    [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];

  logic                  ld_fire;
  logic                  at_last_word;
  logic                  beat_final;
  logic                  len_err;
  logic                  rd_oob;
  logic                  wr_req;
  logic                  wr_oob;
  logic                  wr_commit;
  logic                  drain_go;
  logic                  drain_done;
  logic [OUT_PW-1:0]     rptr;

  // ---------------------------------------------------------------------------
  // Load-stream and access qualifiers
  // ---------------------------------------------------------------------------
  assign ld_fire      = ld_valid && ld_ready;
  assign at_last_word = (wptr_q == WPTR_LAST);
  // A load ends on ld_last or on the last word, whichever comes first.
  assign beat_final   = ld_fire && (ld_last || at_last_word);
  // Correct length means ld_last coincides exactly with the last word.
  assign len_err      = ld_fire && (ld_last != at_last_word);

  assign rd_oob    = input_en && (input_addr >= IN_LIMIT);
  assign wr_req    = output_en && output_we;
  assign wr_oob    = wr_req && (output_addr >= OUT_LIMIT);
  assign wr_commit = wr_req && !wr_oob && (state_q == S_RUN);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ld_fire)    state_d = beat_final ? S_START : S_LOAD;
      S_LOAD:  if (beat_final) state_d = S_START;
      S_START:                 state_d = S_RUN;
      S_RUN:   if (conv_done)  state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    conv_start = (state_q == S_START);
    busy       = (state_q != S_IDLE);
    drain_go   = (state_q == S_RUN) && conv_done;
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Write pointer and sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    if (ld_fire) begin
      wptr_d = beat_final ? '0 : wptr_q + 1'b1;
    end
  end

  always_comb begin
    error_d = error_q;
    // A new load starts with a clean flag; a fault in the same cycle still wins.
    if ((state_q == S_IDLE) && ld_fire) error_d = 1'b0;
    if (len_err || rd_oob || wr_oob)    error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

  // ---------------------------------------------------------------------------
  // Input tensor memory (not reset; a short load leaves old words in place)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      in_mem[wptr_q] <= ld_data;
    end
  end

  assign input_data = (input_en && !rd_oob) ? in_mem[input_addr[IN_PW-1:0]]
                                            : '0;

  // ---------------------------------------------------------------------------
  // Output tensor memory: cleared while conv_start is high, written in RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
    end else if (state_q == S_START) begin
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
    end else if (wr_commit) begin
      out_mem_q[output_addr[OUT_PW-1:0]] <= output_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Result stream
  // ---------------------------------------------------------------------------
  conv_tensor_drain #(
    .DEPTH(OUT_DEPTH)
  ) u_drain (
    .clk          (clk),
    .rst          (rst),
    .drain_go_i   (drain_go),
    .rd_ready_i   (rd_ready),
    .rptr_o       (rptr),
    .rd_valid_o   (rd_valid),
    .rd_last_o    (rd_last),
    .drain_done_o (drain_done)
  );

  assign rd_data = out_mem_q[rptr];

endmodule

// File: tb/tb_conv_tensor_mem.sv
// Self-checking bench for conv_tensor_mem. A transaction-level model (input
// words, output words, error flag, expected result beats) is updated by the
// driver tasks; a negedge process compares the DUT against it every cycle,
// and the scenarios add hand-computed literal expectations.
module tb_conv_tensor_mem;
  import conv_mem_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int IND  = 32;
  localparam int OUTD = 4;
  localparam int IPW  = $clog2(IND);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ld_valid, ld_ready, ld_last;
  logic [DW-1:0] ld_data;
  logic          conv_start, conv_done;
  logic [AW-1:0] input_addr, output_addr;
  logic          input_en, output_we, output_en;
  logic [DW-1:0] input_data, output_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          busy, error;
  conv_state_e   dbg_state;

  conv_tensor_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_DEPTH(IND), .OUT_DEPTH(OUTD)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .conv_start(conv_start), .conv_done(conv_done),
    .input_addr(input_addr), .input_en(input_en), .input_data(input_data),
    .output_addr(output_addr), .output_data(output_data),
    .output_we(output_we), .output_en(output_en),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Model and scoreboard
  // ---------------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] m_in    [IND];
  bit            m_known [IND];
  logic [DW-1:0] m_out   [OUTD];
  bit            m_err = 1'b0;
  bit            m_run = 1'b0;
  logic [DW:0]   exp_q[$];     // {last, data}
  logic [DW-1:0] got_q[$];
  int            start_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   e_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("error", 32'(error), 32'(m_err));
      if (!input_en || input_addr >= AW'(IND))
        chk("input_data_zero", 32'(input_data), 32'd0);
      else if (m_known[input_addr[IPW-1:0]])
        chk("input_data", 32'(input_data), 32'(m_in[input_addr[IPW-1:0]]));
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (prev_stall) begin
        chk("stall_data", 32'(rd_data), 32'(prev_data));
        chk("stall_last", 32'(rd_last), 32'(prev_last));
      end
      if (conv_start) start_cnt++;
      if (rd_valid && rd_ready && exp_q.size() != 0) begin
        e_beat = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e_beat[DW-1:0]));
        chk("rd_last", 32'(rd_last), 32'(e_beat[DW]));
        got_q.push_back(rd_data);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n beats of base+i; ld_last on beat last_idx (-1: never).
  task automatic load_tensor(input int n, input int last_idx,
                             input logic [DW-1:0] base, input logic exp_err);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(base + i);
      ld_last  = (i == last_idx);
      step();
      m_in[i]    = DW'(base + i);
      m_known[i] = 1'b1;
      if (i == 0) m_err = 1'b0;
      // Error unless ld_last lands exactly on the final word.
      if ((i == last_idx) != (i == IND - 1)) m_err = 1'b1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int k = 0; k < OUTD; k++) m_out[k] = '0;
    chk("conv_start_pulse", 32'(conv_start), 32'd1);
    chk("busy_in_start", 32'(busy), 32'd1);
    chk("ld_ready_in_start", 32'(ld_ready), 32'd0);
    chk("error_after_load", 32'(error), 32'(exp_err));
    step();
    chk("conv_start_single", 32'(conv_start), 32'd0);
    m_run = 1'b1;
  endtask

  task automatic write_out(input int addr, input logic [DW-1:0] data);
    output_en   = 1'b1;
    output_we   = 1'b1;
    output_addr = AW'(addr);
    output_data = data;
    step();
    if (addr >= OUTD) m_err = 1'b1;
    else if (m_run)   m_out[addr] = data;
    output_en = 1'b0;
    output_we = 1'b0;
  endtask

  task automatic read_in(input int addr, input logic [DW-1:0] exp_lit);
    input_en   = 1'b1;
    input_addr = AW'(addr);
    @(negedge clk);
    chk("read_literal", 32'(input_data), 32'(exp_lit));
    step();
    if (addr >= IND) m_err = 1'b1;
    input_en = 1'b0;
  endtask

  // Pulse conv_done and drain with rd_ready following pat[cycle%4].
  // abort_after >= 0 stops after that many accepted beats (caller resets).
  task automatic drain(input logic [3:0] pat, input int abort_after,
                       input int exp_cycles, input logic [4*DW-1:0] lit);
    int cyc;
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    m_run = 1'b0;
    for (int k = 0; k < OUTD; k++) exp_q.push_back({(k == OUTD - 1), m_out[k]});
    got_q.delete();
    chk("rd_valid_rise", 32'(rd_valid), 32'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      if (abort_after >= 0 && got_q.size() == abort_after) break;
      rd_ready = pat[cyc % 4];
      step();
      cyc++;
    end
    rd_ready = 1'b1;
    if (abort_after < 0) begin
      chk("drain_complete", 32'(exp_q.size()), 32'd0);
      chk("drain_cycles", 32'(cyc), 32'(exp_cycles));
      chk("beat_count", 32'(got_q.size()), 32'(OUTD));
      for (int k = 0; k < OUTD && k < got_q.size(); k++)
        chk("beat_literal", 32'(got_q[k]), 32'(lit[k*DW +: DW]));
      chk("busy_after_drain", 32'(busy), 32'd0);
      chk("state_after_drain", 32'(dbg_state), 32'(S_IDLE));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_ld_ready"},   32'(ld_ready),   32'd1);
    chk({tag, "_conv_start"}, 32'(conv_start), 32'd0);
    chk({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
    chk({tag, "_rd_last"},    32'(rd_last),    32'd0);
    chk({tag, "_state"},      32'(dbg_state),  32'(S_IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    ld_valid = 0; ld_data = 0; ld_last = 0; conv_done = 0;
    input_addr = 0; input_en = 0; output_addr = 0; output_data = 0;
    output_we = 0; output_en = 0; rd_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

    // conv_done while idle is ignored.
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    chk("done_in_idle_busy", 32'(busy), 32'd0);

    // Full load 0x00..0x1F, run, out-of-range accesses, streaming drain.
    load_tensor(32, 31, 8'h00, 1'b0);
    read_in(5, 8'h05);
    write_out(0, 8'd10);
    write_out(1, 8'd20);
    write_out(2, 8'd30);
    write_out(3, 8'd40);
    read_in(40, 8'h00);
    chk("error_read_oob", 32'(error), 32'd1);
    write_out(4, 8'd99);
    drain(4'b1111, -1, 4, {8'd40, 8'd30, 8'd20, 8'd10});
    chk("error_sticky", 32'(error), 32'd1);

    // New load clears error; overwritten word; stalled drain 1,0,0,1.
    load_tensor(32, 31, 8'hA0, 1'b0);
    write_out(2, 8'hC2);
    write_out(0, 8'hC0);
    write_out(3, 8'hC3);
    write_out(1, 8'hC1);
    write_out(1, 8'hD1);
    drain(4'b1001, -1, 8, {8'hC3, 8'hC2, 8'hD1, 8'hC0});

    // Short load (ld_last on beat 10): error, old words kept, out_mem cleared.
    load_tensor(11, 10, 8'h40, 1'b1);
    read_in(10, 8'h4A);
    read_in(11, 8'hAB);
    drain(4'b1111, -1, 4, {8'h00, 8'h00, 8'h00, 8'h00});

    // Correct load, then reset after two drain beats.
    load_tensor(32, 31, 8'h60, 1'b0);
    write_out(0, 8'd5);
    write_out(1, 8'd6);
    write_out(2, 8'd7);
    write_out(3, 8'd8);
    drain(4'b1111, 2, 0, '0);
    chk("abort_beats", 32'(got_q.size()), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    m_err = 1'b0;
    m_run = 1'b0;
    for (int k = 0; k < OUTD; k++) m_out[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fresh run after reset.
    load_tensor(32, 31, 8'h80, 1'b0);
    write_out(0, 8'h11);
    write_out(1, 8'h22);
    write_out(2, 8'h33);
    write_out(3, 8'h44);
    drain(4'b1111, -1, 4, {8'h44, 8'h33, 8'h22, 8'h11});

    // 32 beats with no ld_last: error, load still ends at the last word.
    load_tensor(32, -1, 8'h20, 1'b1);
    read_in(31, 8'h3F);
    drain(4'b1111, -1, 4, {8'h00, 8'h00, 8'h00, 8'h00});

    @(negedge clk);
    chk("conv_start_pulses", 32'(start_cnt), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/conv_tensor_mem.md
# conv_tensor_mem

Synthesizable responder for the `conv2d` memory interface; replaces the behavioural input/output memories of the simulation bench. Loads an input tensor from a host valid/ready stream and issues a one-cycle `conv_start`. It then serves `conv2d` reads and captures its writes. When `conv_done` arrives, it drains the output tensor to a host result stream. It sits between the host/DMA side and one `conv2d` instance.

## Interface
- `DATA_WIDTH`, 8, tensor element width
- `ADDR_WIDTH`, 16, `conv2d` address width
- `IN_DEPTH`, 32, input tensor words (BATCH·IN_CHANNELS·IN_HEIGHT·IN_WIDTH)
- `OUT_DEPTH`, 4, output tensor words (BATCH·OUT_CHANNELS·OUT_HEIGHT·OUT_WIDTH)

Ports (direction, width, meaning):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ld_valid`  in  1  host load beat valid
- `ld_ready`  out  1  load beat accepted when both high
- `ld_data`  in  DATA_WIDTH  input tensor element, address order
- `ld_last`  in  1  marks final load beat
- `conv_start`  out  1  one-cycle start pulse to `conv2d`
- `conv_done`  in  1  `conv2d` done
- `input_addr`  in  ADDR_WIDTH  read address
- `input_en`  in  1  read enable
- `input_data`  out  DATA_WIDTH  combinational read data
- `output_addr`  in  ADDR_WIDTH  write address
- `output_data`  in  DATA_WIDTH  write data
- `output_we`, `output_en`  in  1 each  write qualifiers; a write needs both high
- `rd_valid`  out  1  result beat valid
- `rd_ready`  in  1  host accepts result beat
- `rd_data`  out  DATA_WIDTH  output tensor element
- `rd_last`  out  1  final result beat
- `busy`  out  1  state ≠ IDLE
- `error`  out  1  sticky protocol/range error

## Operation
- States:
  - IDLE → LOAD on the first accepted beat.
  - LOAD → START after beat IN_DEPTH-1 is accepted, or on an accepted beat with `ld_last`.
  - START → RUN after one cycle.
  - RUN → DRAIN when `conv_done` is sampled high.
  - DRAIN → IDLE on the handshake of the final beat.
- `ld_ready` = (state is IDLE or LOAD). Each accepted beat writes `in_mem[wptr]` and increments `wptr`.
- Load-length check: `ld_last` before beat IN_DEPTH-1 sets `error` and ends the load; unwritten words keep their old contents. `ld_last` low on beat IN_DEPTH-1 also sets `error`, and the load ends there.
- `error` clears on the first accepted beat in IDLE.
- START drives `conv_start`=1 and clears `out_mem` to 0.
- Reads, combinational, valid in any state: `input_data` = `in_mem[input_addr]` if `input_en` and `input_addr` < IN_DEPTH, otherwise 0.
- Writes in RUN only: `out_mem[output_addr]` ← `output_data` on a clock edge where `output_en`, `output_we` and `output_addr` < OUT_DEPTH are all true.
- Writes outside RUN are dropped.
- Any enabled access with an address at or above its depth sets `error`.
- A write in the same cycle as `conv_done` is committed.
- DRAIN:
  - `rd_data` = `out_mem[rptr]`; `rd_valid`=1; `rd_last` = (`rptr` == OUT_DEPTH-1).
  - `rptr` advances on `rd_valid && rd_ready`.
  - `rd_data` and `rd_last` stay stable while `rd_ready` is low.
- `conv_done` outside RUN is ignored.
- Arithmetic: `wptr` and `rptr` are $clog2(depth) bits wide. Address compares are done at ADDR_WIDTH, zero-extended. No wrap-around is possible, since the pointers stop at depth-1.

## Timing
- Reset values (asynchronous): state IDLE, `wptr`=`rptr`=0, `out_mem`=0, `error`=0, `conv_start`=0, `rd_valid`=0, `rd_last`=0, `busy`=0, `ld_ready`=1. `in_mem` is not reset.
- Load throughput is one beat per cycle.
- `conv_start` is high exactly one cycle: the cycle after the final load beat.
- `rd_valid` rises the cycle after `conv_done` is sampled.
- With `rd_ready` held high, the drain takes OUT_DEPTH cycles and `busy` falls the cycle after the last beat.
- Total latency from last load beat to first result beat is 2 + (cycles `conv2d` takes to assert `conv_done`).
- Reset asserted mid-operation aborts immediately to the reset values. A partial drain is discarded.

## Structure
- Package `conv_mem_pkg`:
  - state enum (`S_IDLE`, `S_LOAD`, `S_START`, `S_RUN`, `S_DRAIN`)
  - pointer-width localparam helpers
- One sub-module `conv_tensor_drain`: `rptr` counter plus valid/ready/last logic for the result stream. It takes a `drain_go` pulse and returns `drain_done`.
- The top level holds the FSM, both memories and the range checks.

## Test plan
- Load 0x00..0x1F with `ld_last` on beat 31 → `conv_start` is one pulse the next cycle; reading `input_addr`=5 returns 0x05; `error`=0.
- In RUN, write 10, 20, 30, 40 to addresses 0–3, then pulse `conv_done` → with `rd_ready`=1, the bench sees 10, 20, 30, 40 on consecutive cycles, `rd_last` only on 40, then `busy`=0.
- Same run with `rd_ready` toggling 1,0,0,1,… → no beat is lost or duplicated, and `rd_data` is stable while stalled.
- `ld_last` on beat 10 → `error`=1, `conv_start` fires after beat 10; a following new load clears `error`.
- Read at `input_addr`=40 and write at `output_addr`=4 → `input_data`=0, `out_mem` unchanged, `error`=1.
- Assert `rst` after 2 drain beats → all outputs return to reset values asynchronously; a fresh load and run completes correctly.
